ac_ctrl_unit: RTL and testbench

//  Control/sequencing stage of the accumulator computer, directly upstream of the alu: fetches 2-byte

---
 rtl/ac_pkg.sv | 33 +++
 rtl/ac_ctrl_unit.sv | 149 ++++++++++++++
 tb/tb_ac_ctrl_unit.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ac_pkg.sv
// Shared definitions for the accumulator computer control unit:
// opcodes, ALU operation codes and the sequencer state encoding.
package ac_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH_OP  = 3'd1,
      S_FETCH_AD  = 3'd2,
      S_DECODE    = 3'd3,
      S_READ_MEM  = 3'd4,
      S_EXEC      = 3'd5,
      S_WRITE_MEM = 3'd6,
      S_HALT      = 3'd7
   } state_t;

   function automatic logic is_legal(input logic [3:0] op);
      return (op <= OP_JC) || (op == OP_HLT);
   endfunction

endpackage

// File: rtl/ac_ctrl_unit.sv
// Fetch/decode/execute sequencer for the accumulator computer. Drives the
// external alu and a single req/ack memory port; holds PC, ACC and flags.
module ac_ctrl_unit
   import ac_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter bit         AUTO_RUN = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       run_i,
   output logic       mem_req_o,
   output logic       mem_we_o,
   output logic [7:0] mem_addr_o,
   output logic [7:0] mem_wdata_o,
   input  logic [7:0] mem_rdata_i,
   input  logic       mem_ack_i,
   output logic [7:0] alu_x_o,
   output logic [7:0] alu_y_o,
   output logic [2:0] alu_op_o,
   input  logic [7:0] alu_r_i,
   input  logic       alu_fz_i,
   input  logic       alu_fc_i,
   output logic [7:0] acc_o,
   output logic [7:0] pc_o,
   output logic       flag_z_o,
   output logic       flag_c_o,
   output logic       halt_o,
   output logic       err_o
);

   // Memory handshake: a transfer completes on the rising edge where
   // mem_req_o and mem_ack_i are both high; req is held until then and is
   // decoded from state, so address/we/wdata are stable for the whole wait.

   state_t     state_q, state_d;
   logic [7:0] pc_q, acc_q, mar_q, mdr_q;
   logic [3:0] ir_q;
   logic       z_q, c_q, err_q;
   logic       xfer;
   logic       taken;

   assign xfer  = mem_req_o & mem_ack_i;
   assign taken = (ir_q == OP_JMP) || ((ir_q == OP_JZ) && z_q) || ((ir_q == OP_JC) && c_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (run_i || AUTO_RUN) state_d = S_FETCH_OP;
         S_FETCH_OP:  if (xfer) state_d = S_FETCH_AD;
         S_FETCH_AD:  if (xfer) state_d = S_DECODE;
         S_DECODE: begin
            case (ir_q)
               OP_LDA, OP_ADD, OP_SUB: state_d = S_READ_MEM;
               OP_STA:                 state_d = S_WRITE_MEM;
               OP_HLT:                 state_d = S_HALT;
               default:                state_d = S_FETCH_OP;
            endcase
         end
         S_READ_MEM:  if (xfer) state_d = S_EXEC;
         S_EXEC:      state_d = S_FETCH_OP;
         S_WRITE_MEM: if (xfer) state_d = S_FETCH_OP;
         S_HALT:      state_d = S_HALT;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_req_o  = 1'b0;
      mem_we_o   = 1'b0;
      mem_addr_o = 8'h00;
      alu_op_o   = ALU_ADD;
      halt_o     = 1'b0;
      case (state_q)
         S_FETCH_OP, S_FETCH_AD: begin
            mem_req_o  = 1'b1;
            mem_addr_o = pc_q;
         end
         S_READ_MEM: begin
            mem_req_o  = 1'b1;
            mem_addr_o = mar_q;
         end
         S_WRITE_MEM: begin
            mem_req_o  = 1'b1;
            mem_we_o   = 1'b1;
            mem_addr_o = mar_q;
         end
         S_EXEC:      if (ir_q == OP_SUB) alu_op_o = ALU_SUB;
         S_HALT:      halt_o = 1'b1;
         default:     ;
      endcase
   end

   // Datapath registers; every update is gated by the owning state's exit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q  <= RESET_PC;
         acc_q <= 8'h00;
         ir_q  <= 4'h0;
         mar_q <= 8'h00;
         mdr_q <= 8'h00;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            S_FETCH_OP: if (xfer) begin
               ir_q <= mem_rdata_i[7:4];
               pc_q <= pc_q + 8'd1;
            end
            S_FETCH_AD: if (xfer) begin
               mar_q <= mem_rdata_i;
               pc_q  <= pc_q + 8'd1;
            end
            S_DECODE: begin
               if (taken)            pc_q  <= mar_q;
               if (!is_legal(ir_q))  err_q <= 1'b1;
            end
            S_READ_MEM: if (xfer) mdr_q <= mem_rdata_i;
            S_EXEC: begin
               if (ir_q == OP_LDA) begin
                  acc_q <= mdr_q;
                  z_q   <= (mdr_q == 8'h00);
               end else begin
                  acc_q <= alu_r_i;
                  z_q   <= alu_fz_i;
                  c_q   <= alu_fc_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_wdata_o = acc_q;
   assign alu_x_o     = acc_q;
   assign alu_y_o     = mdr_q;
   assign acc_o       = acc_q;
   assign pc_o        = pc_q;
   assign flag_z_o    = z_q;
   assign flag_c_o    = c_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_ac_ctrl_unit.sv
// Directed bench for ac_ctrl_unit: behavioural alu and memory with a
// programmable ack delay, a table of small programs, and corner sequences.
module tb_ac_ctrl_unit;
   import ac_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run_i = 1'b0;
   logic       mem_req, mem_we, mem_ack;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0] alu_x, alu_y, alu_r;
   logic [2:0] alu_op;
   logic       alu_fz, alu_fc;
   logic [7:0] acc, pc;
   logic       fz, fc, halt, err;

   always #5 clk = ~clk;

   ac_ctrl_unit #(.RESET_PC(8'h00), .AUTO_RUN(1'b0)) dut (
      .clk_i(clk), .rst_ni(rst_n), .run_i(run_i),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
      .alu_x_o(alu_x), .alu_y_o(alu_y), .alu_op_o(alu_op),
      .alu_r_i(alu_r), .alu_fz_i(alu_fz), .alu_fc_i(alu_fc),
      .acc_o(acc), .pc_o(pc), .flag_z_o(fz), .flag_c_o(fc),
      .halt_o(halt), .err_o(err)
   );

   // Reference alu: 9-bit arithmetic, bit 8 is carry for ADD and borrow for SUB.
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum = 9'h000;
      if (alu_op == ALU_SUB) alu_sum = {1'b0, alu_x} - {1'b0, alu_y};
      else                   alu_sum = {1'b0, alu_x} + {1'b0, alu_y};
      alu_r  = alu_sum[7:0];
      alu_fc = alu_sum[8];
      alu_fz = (alu_sum[7:0] == 8'h00);
   end

   logic [7:0] mem [256];
   logic [7:0] dly = 8'd0;
   logic [7:0] wait_cnt;
   logic [7:0] wr_cnt;
   logic       ld_en = 1'b0;
   logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;

   assign mem_ack   = mem_req & (wait_cnt == dly);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  wait_cnt <= 8'd0;
      else if (!mem_req || mem_ack) wait_cnt <= 8'd0;
      else                         wait_cnt <= wait_cnt + 8'd1;
   end

   always @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
         wr_cnt       <= 8'd0;
      end else if (mem_req && mem_ack && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt        <= wr_cnt + 8'd1;
      end
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic clear_mem;
      for (int a = 0; a < 256; a++) load(8'(a), 8'h00);
   endtask

   // Program image: p holds bytes 00..07 (leftmost byte at address 00),
   // t holds four bytes starting at taddr.
   typedef struct packed {
      logic [63:0] p;
      logic [7:0]  taddr;
      logic [31:0] t;
      logic [7:0]  m10, m11, dly;
      logic [7:0]  e_acc, e_pc;
      logic        e_z, e_c;
      logic [7:0]  e_cyc, e_wr, e_m12;
   } vec_t;

   vec_t vecs [6];

   task automatic run_vec(input int idx, input vec_t v);
      int  n;
      bit  done;
      rst_n = 1'b0;
      run_i = 1'b0;
      dly   = v.dly;
      clear_mem();
      for (int i = 0; i < 8; i++) load(8'(i), v.p[63-8*i -: 8]);
      for (int i = 0; i < 4; i++) load(v.taddr + 8'(i), v.t[31-8*i -: 8]);
      load(8'h10, v.m10);
      load(8'h11, v.m11);
      load(8'h12, 8'hAA);
      rst_n = 1'b1;
      tick();
      chk1($sformatf("v%0d idle_req", idx), mem_req, 1'b0);
      run_i = 1'b1;
      n = 0;
      done = 1'b0;
      while (n < 400 && !done) begin
         tick();
         n++;
         if (halt) done = 1'b1;
      end
      run_i = 1'b0;
      chk1($sformatf("v%0d halted", idx), halt, 1'b1);
      chk32($sformatf("v%0d cycles", idx), n - 1, 32'(v.e_cyc));
      chk8($sformatf("v%0d acc", idx), acc, v.e_acc);
      chk8($sformatf("v%0d pc", idx), pc, v.e_pc);
      chk1($sformatf("v%0d z", idx), fz, v.e_z);
      chk1($sformatf("v%0d c", idx), fc, v.e_c);
      chk1($sformatf("v%0d err", idx), err, 1'b0);
      chk8($sformatf("v%0d writes", idx), wr_cnt, v.e_wr);
      chk8($sformatf("v%0d m12", idx), mem[8'h12], v.e_m12);
      repeat (3) tick();
      chk1($sformatf("v%0d halt_noreq", idx), mem_req, 1'b0);
   endtask

   initial begin
      int  n;
      bit  ok;

      // LDA 10; SUB 11; HLT  (7-3), zero wait then 3-cycle ack
      vecs[0] = '{p:64'h1010_4011_F000_0000, taddr:8'h40, t:32'h0,
                  m10:8'h07, m11:8'h03, dly:8'd0, e_acc:8'h04, e_pc:8'h06,
                  e_z:1'b0, e_c:1'b0, e_cyc:8'd13, e_wr:8'd0, e_m12:8'hAA};
      vecs[1] = '{p:64'h1010_4011_F000_0000, taddr:8'h40, t:32'h0,
                  m10:8'h07, m11:8'h03, dly:8'd3, e_acc:8'h04, e_pc:8'h06,
                  e_z:1'b0, e_c:1'b0, e_cyc:8'd37, e_wr:8'd0, e_m12:8'hAA};
      // LDA 10; SUB 11; JZ 20 -> HLT at 20 (low opcode nibbles are junk)
      vecs[2] = '{p:64'h1A10_4211_6020_0000, taddr:8'h20, t:32'hF000_0000,
                  m10:8'h02, m11:8'h02, dly:8'd0, e_acc:8'h00, e_pc:8'h22,
                  e_z:1'b1, e_c:1'b0, e_cyc:8'd16, e_wr:8'd0, e_m12:8'hAA};
      // LDA 10; SUB 11 (3-4); JC 30 -> JZ 40 untaken; HLT at 32
      vecs[3] = '{p:64'h1010_4011_7030_0000, taddr:8'h30, t:32'h6040_F000,
                  m10:8'h03, m11:8'h04, dly:8'd0, e_acc:8'hFF, e_pc:8'h34,
                  e_z:1'b0, e_c:1'b1, e_cyc:8'd19, e_wr:8'd0, e_m12:8'hAA};
      // LDA 10; ADD 11 (FF+01); STA 12; HLT
      vecs[4] = '{p:64'h1010_3011_2012_F000, taddr:8'h40, t:32'h0,
                  m10:8'hFF, m11:8'h01, dly:8'd0, e_acc:8'h00, e_pc:8'h08,
                  e_z:1'b1, e_c:1'b1, e_cyc:8'd17, e_wr:8'd1, e_m12:8'h00};
      vecs[5] = '{p:64'h1010_3011_2012_F000, taddr:8'h40, t:32'h0,
                  m10:8'hFF, m11:8'h01, dly:8'd2, e_acc:8'h00, e_pc:8'h08,
                  e_z:1'b1, e_c:1'b1, e_cyc:8'd39, e_wr:8'd1, e_m12:8'h00};

      // Reset values while held in reset
      #1;
      chk8("rst pc", pc, 8'h00);
      chk8("rst acc", acc, 8'h00);
      chk1("rst z", fz, 1'b0);
      chk1("rst c", fc, 1'b0);
      chk1("rst halt", halt, 1'b0);
      chk1("rst err", err, 1'b0);
      chk1("rst req", mem_req, 1'b0);
      chk1("rst we", mem_we, 1'b0);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Asynchronous reset while an address fetch is outstanding
      rst_n = 1'b0;
      dly   = 8'd3;
      clear_mem();
      load(8'h00, 8'h10); load(8'h01, 8'h10);
      load(8'h02, 8'h10); load(8'h03, 8'h10);
      load(8'h10, 8'h07);
      rst_n = 1'b1;
      tick();
      run_i = 1'b1;
      n = 0;
      while (n < 100 && acc != 8'h07) begin tick(); n++; end
      chk8("mid acc loaded", acc, 8'h07);
      n = 0;
      while (n < 100 && dut.state_q != S_FETCH_AD) begin tick(); n++; end
      run_i = 1'b0;
      #2;
      chk1("mid req before rst", mem_req, 1'b1);
      chk8("mid pc before rst", pc, 8'h03);
      rst_n = 1'b0;
      #1;
      chk1("mid rst req", mem_req, 1'b0);
      chk8("mid rst pc", pc, 8'h00);
      chk8("mid rst acc", acc, 8'h00);
      chk1("mid rst idle", dut.state_q == S_IDLE, 1'b1);
      #3;
      rst_n = 1'b1;
      repeat (3) tick();
      chk1("mid stays idle", mem_req, 1'b0);

      // Slow memory, illegal opcode at FE whose address byte sits at FF
      rst_n = 1'b0;
      dly   = 8'd3;
      clear_mem();
      load(8'h00, 8'h10); load(8'h01, 8'h10);
      load(8'h02, 8'h40); load(8'h03, 8'h11);
      load(8'h04, 8'h50); load(8'h05, 8'hFE);
      load(8'hFE, 8'h9C); load(8'hFF, 8'h00);
      load(8'h10, 8'h07); load(8'h11, 8'h03);
      rst_n = 1'b1;
      tick();
      run_i = 1'b1;
      n  = 0;
      ok = 1'b0;
      while (n < 300 && !ok) begin
         tick();
         n++;
         if (err) ok = 1'b1;
      end
      run_i = 1'b0;
      chk1("ill err", err, 1'b1);
      chk8("ill pc wrap", pc, 8'h00);
      chk8("ill acc", acc, 8'h04);
      chk1("ill z", fz, 1'b0);
      chk1("ill c", fc, 1'b0);
      chk1("ill halt", halt, 1'b0);
      repeat (20) tick();
      chk1("ill err sticky", err, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
